// File: rtl/extmem_cycle_ctrl.sv
// 68000 external RAM/ROM bus-cycle sequencer: per-device wait states, memory strobes, dtack/berr.
// dtack at edge N+1 after enable is sampled; strobe drops stall the wait count; ROM write or timeout gives berr.
module extmem_cycle_ctrl #(
  parameter int unsigned ROM_WAIT = 2,
  parameter int unsigned RAM_WAIT = 0,
  parameter int unsigned TIMEOUT  = 64
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  input  logic is_rom,
  input  logic rw,
  input  logic uds,
  input  logic lds,
  output logic dtack,
  output logic berr,
  output logic rom_oe,
  output logic ram_oe,
  output logic ram_we,
  output logic ram_ub,
  output logic ram_lb
);

  typedef enum logic [1:0] {IDLE, WAIT, ACK, ERR} state_t;

  localparam logic [3:0] ROM_WCNT = 4'(ROM_WAIT);
  localparam logic [3:0] RAM_WCNT = 4'(RAM_WAIT);
  localparam logic [7:0] TLAST    = 8'(TIMEOUT - 1);

  state_t     state_q;
  logic [3:0] wcnt_q;
  logic [7:0] tcnt_q;
  logic       rom_q;
  logic       rw_q;
  logic       strobe;
  logic       act;

  assign strobe = uds | lds;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      wcnt_q  <= '0;
      tcnt_q  <= '0;
      rom_q   <= 1'b0;
      rw_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (enable) begin
            if (is_rom && !rw) begin
              state_q <= ERR;
            end else begin
              state_q <= WAIT;
              wcnt_q  <= is_rom ? ROM_WCNT : RAM_WCNT;
              tcnt_q  <= '0;
              rom_q   <= is_rom;
              rw_q    <= rw;
            end
          end
        end
        WAIT: begin
          tcnt_q <= tcnt_q + 8'd1;
          if (!enable) begin
            state_q <= IDLE;
          end else if (tcnt_q == TLAST) begin
            state_q <= ERR;
          end else if (strobe && wcnt_q == 4'd0) begin
            state_q <= ACK;
          end else if (strobe) begin
            // wait states only elapse while a data strobe is present
            wcnt_q <= wcnt_q - 4'd1;
          end
        end
        ACK, ERR: begin
          if (!enable) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign act    = (state_q == WAIT) || (state_q == ACK);
  assign dtack  = (state_q == ACK);
  assign berr   = (state_q == ERR);
  assign rom_oe = act &  rom_q &  rw_q;
  assign ram_oe = act & ~rom_q &  rw_q;
  assign ram_we = act & ~rom_q & ~rw_q & strobe;
  assign ram_ub = act & ~rom_q & uds;
  assign ram_lb = act & ~rom_q & lds;

endmodule

// File: tb/tb_extmem_cycle_ctrl.sv
// Directed bench for extmem_cycle_ctrl with default parameters (ROM_WAIT=2, RAM_WAIT=0, TIMEOUT=64).
module tb_extmem_cycle_ctrl;

  logic clk = 1'b0;
  logic reset, enable, is_rom, rw, uds, lds;
  logic dtack, berr, rom_oe, ram_oe, ram_we, ram_ub, ram_lb;

  int checks = 0;
  int errors = 0;

  extmem_cycle_ctrl dut (
    .clk    (clk),
    .reset  (reset),
    .enable (enable),
    .is_rom (is_rom),
    .rw     (rw),
    .uds    (uds),
    .lds    (lds),
    .dtack  (dtack),
    .berr   (berr),
    .rom_oe (rom_oe),
    .ram_oe (ram_oe),
    .ram_we (ram_we),
    .ram_ub (ram_ub),
    .ram_lb (ram_lb)
  );

  always #5 clk = ~clk;

  // output vector order: {dtack, berr, rom_oe, ram_oe, ram_we, ram_ub, ram_lb}
  function automatic logic [6:0] outs();
    return {dtack, berr, rom_oe, ram_oe, ram_we, ram_ub, ram_lb};
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic seen;
    reset = 1'b1; enable = 1'b0; is_rom = 1'b0; rw = 1'b1; uds = 1'b0; lds = 1'b0;
    tick(); tick();
    chk("reset", 32'(outs()), 32'h00);
    reset = 1'b0;

    // RAM read, no wait states
    enable = 1'b1; is_rom = 1'b0; rw = 1'b1; uds = 1'b1; lds = 1'b1;
    tick(); chk("ram_rd_e0", 32'(outs()), 32'(7'b0001011));
    tick(); chk("ram_rd_e1", 32'(outs()), 32'(7'b1001011));
    enable = 1'b0; uds = 1'b0; lds = 1'b0;
    tick(); chk("ram_rd_idle", 32'(outs()), 32'h00);

    // ROM read, two wait states
    enable = 1'b1; is_rom = 1'b1; rw = 1'b1; lds = 1'b1;
    tick(); chk("rom_rd_e0", 32'(outs()), 32'(7'b0010000));
    tick(); chk("rom_rd_e1", 32'(outs()), 32'(7'b0010000));
    tick(); chk("rom_rd_e2", 32'(outs()), 32'(7'b0010000));
    tick(); chk("rom_rd_e3", 32'(outs()), 32'(7'b1010000));
    enable = 1'b0; lds = 1'b0;
    tick(); chk("rom_rd_idle", 32'(outs()), 32'h00);

    // RAM byte write with late lower strobe
    enable = 1'b1; is_rom = 1'b0; rw = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick(); chk("late_wr_wait", 32'(outs()), 32'h00);
    end
    lds = 1'b1; #1;
    chk("late_wr_strobe", 32'(outs()), 32'(7'b0000101));
    tick(); chk("late_wr_ack", 32'(outs()), 32'(7'b1000101));
    lds = 1'b0; #1;
    chk("late_wr_nostrobe", 32'(outs()), 32'(7'b1000000));
    enable = 1'b0;
    tick(); chk("late_wr_idle", 32'(outs()), 32'h00);

    // ROM write -> bus error
    enable = 1'b1; is_rom = 1'b1; rw = 1'b0; uds = 1'b1;
    tick(); chk("rom_wr_e0", 32'(outs()), 32'(7'b0100000));
    tick(); chk("rom_wr_hold", 32'(outs()), 32'(7'b0100000));
    enable = 1'b0; uds = 1'b0;
    tick(); chk("rom_wr_idle", 32'(outs()), 32'h00);

    // Timeout: RAM write with no strobe
    enable = 1'b1; is_rom = 1'b0; rw = 1'b0;
    tick();
    seen = 1'b0;
    for (int i = 1; i < 64; i++) begin
      tick();
      seen = seen | dtack | berr;
    end
    chk("tmo_early", 32'(seen), 32'h0);
    tick(); chk("tmo_berr", 32'(outs()), 32'(7'b0100000));
    enable = 1'b0;
    tick(); chk("tmo_idle", 32'(outs()), 32'h00);

    // Abort in WAIT with wcnt=1
    enable = 1'b1; is_rom = 1'b1; rw = 1'b1; lds = 1'b1;
    tick(); tick(); chk("abort_wait", 32'(outs()), 32'(7'b0010000));
    enable = 1'b0;
    tick(); chk("abort_idle", 32'(outs()), 32'h00);
    tick(); chk("abort_no_ack", 32'(outs()), 32'h00);

    // Reset during ACK restarts the cycle with the full wait count
    enable = 1'b1;
    tick(); tick(); tick(); tick();
    chk("rst_pre_ack", 32'(outs()), 32'(7'b1010000));
    reset = 1'b1;
    tick(); chk("rst_clear", 32'(outs()), 32'h00);
    reset = 1'b0;
    tick(); chk("rst_e0", 32'(outs()), 32'(7'b0010000));
    tick(); chk("rst_e1", 32'(outs()), 32'(7'b0010000));
    tick(); chk("rst_e2", 32'(outs()), 32'(7'b0010000));
    tick(); chk("rst_e3", 32'(outs()), 32'(7'b1010000));
    enable = 1'b0; lds = 1'b0;
    tick(); chk("rst_idle", 32'(outs()), 32'h00);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/extmem_cycle_ctrl.md
Name: extmem_cycle_ctrl

Overview:
Sequences each 68000 bus cycle to external RAM/ROM, replacing the fixed immediate-dtack path.
- Inserts per-device wait states.
- Generates RAM/ROM output-enable, write-enable and byte-lane strobes.
- Terminates the cycle with dtack, or with berr on a ROM write or strobe timeout.
- Sits in glue logic between the address decoder (enable, is_rom) and the memory chips. Its dtack/berr are ORed with other glue responders.

Parameters:
ROM_WAIT, 2, wait cycles inserted for ROM accesses (0..15)
RAM_WAIT, 0, wait cycles inserted for RAM accesses (0..15)
TIMEOUT, 64, cycles in WAIT before berr is forced (2..255)

Ports:
clk  input  1  system clock; all state changes on rising edge
reset  input  1  synchronous, active-high reset
enable  input  1  decoder select, high for the whole bus cycle (AS-qualified)
is_rom  input  1  1 = ROM region, 0 = RAM region; valid while enable high
rw  input  1  CPU R/W: 1 = read, 0 = write
uds  input  1  upper data strobe, active-high
lds  input  1  lower data strobe, active-high
dtack  output  1  active-high data acknowledge
berr  output  1  active-high bus error
rom_oe  output  1  ROM output enable
ram_oe  output  1  RAM output enable
ram_we  output  1  RAM write enable
ram_ub  output  1  RAM upper byte lane select
ram_lb  output  1  RAM lower byte lane select

Behaviour:
- State register: IDLE, WAIT, ACK, ERR. On reset (sampled at an edge): state=IDLE, counters=0, all outputs 0.
- Sampled signals: strobe = uds|lds. At the IDLE->WAIT transition, is_rom and rw are latched as rom_q and rw_q; both stay fixed for the cycle.
- IDLE:
  - enable=1 with is_rom=1 and rw=0 -> ERR (ROM write).
  - Otherwise enable=1 -> WAIT. wcnt is loaded with ROM_WAIT or RAM_WAIT; tcnt is set to 0.
- WAIT, evaluated in priority order:
  - enable=0 -> IDLE (aborted cycle, no dtack).
  - Else tcnt==TIMEOUT-1 -> ERR.
  - Else strobe=1 and wcnt==0 -> ACK.
  - Else strobe=1 -> wcnt decrements.
  - tcnt increments every cycle spent in WAIT. wcnt only counts while strobe=1, so a late write strobe does not eat wait states.
- ACK: dtack=1. Stays until enable=0, then -> IDLE.
- ERR: berr=1. Stays until enable=0, then -> IDLE.
- Output decoding:
  - dtack = (state==ACK); berr = (state==ERR). Both are purely state-decoded and glitch-free; dtack and berr are never high together.
  - act = state∈{WAIT,ACK}.
  - rom_oe = act & rom_q & rw_q.
  - ram_oe = act & !rom_q & rw_q.
  - ram_we = act & !rom_q & !rw_q & strobe.
  - ram_ub = act & !rom_q & uds; ram_lb = act & !rom_q & lds.
  - All memory enables are 0 in IDLE and ERR.
- Latency, strobe present from the start:
  - enable sampled high at edge E0 -> WAIT at E0.
  - dtack rises at edge E(N+1), where N is the wait count.
  - RAM_WAIT=0 gives 2 edges from enable to dtack.
- Back-to-back cycles: after ACK/ERR, at least one IDLE cycle precedes the next WAIT, because enable must be seen low.
- Strobe drop in WAIT: wcnt holds; the ack is delayed until strobe returns.
- Timeout: TIMEOUT counts cycles in WAIT, so ERR is entered at the TIMEOUT-th edge after entering WAIT.
- Reset mid-cycle: forces IDLE immediately. If enable is still high after reset, a fresh cycle begins (WAIT with a freshly loaded wcnt).
- Widths: wcnt 4 bits, tcnt 8 bits. No wrap, since ERR is taken before tcnt overflows.

Test Plan:
1. RAM read, RAM_WAIT=0: enable=1, is_rom=0, rw=1, uds=lds=1 at E0 -> ram_oe=1 from E0, dtack=1 at E1. Deassert enable -> dtack=0 and state IDLE next edge.
2. ROM read, ROM_WAIT=2: enable=1, is_rom=1, rw=1, lds=1 -> rom_oe=1 throughout, dtack rises at E3, ram_* all 0.
3. RAM byte write, late strobe: rw=0 with uds=0, lds=0 for 3 cycles, then lds=1 -> ram_we=1 and ram_lb=1 only while lds=1, ram_ub=0, dtack 1 edge after lds is sampled (RAM_WAIT=0).
4. ROM write: enable=1, is_rom=1, rw=0 -> berr=1 at E0, dtack, rom_oe and ram_we never 1. berr clears after enable=0.
5. Timeout, TIMEOUT=64: enable=1 for RAM write, strobes held 0 -> berr=1 at 64 edges after entering WAIT, dtack never asserted.
6. Abort and reset: enable drops in WAIT with wcnt=1 -> IDLE, no dtack. Separately, reset=1 during ACK -> all outputs 0 next edge; with enable still 1, dtack re-asserts after the full wait count.
